aidan_mcnay_debounce: RTL and testbench
=======================================

# aidan_mcnay_debounce

Input-conditioning stage that sits directly upstream of `aidan_mcnay_change_detect`. It takes a raw, asynchronous, possibly bouncing external signal (button or switch) and synchronises it into the `clk` domain. It then debounces it and presents a clean, glitch-free level on `out_signal`, which drives `in_signal` of the change detector. It guarantees that the downstream edge detector sees exactly one transition per physical press or release.

## Interface

Parameters:
- `STABLE_CYCLES`, default 16: consecutive synchronised cycles the new level must persist before `out_signal` follows. Legal range is 1 to 65535. Counter width is `$clog2(STABLE_CYCLES+1)`.
- `RESET_VALUE`, default 1'b0: level loaded into the synchroniser flops and into `out_signal` on reset.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is sampled on `clk`.
- `in_signal`  input  1  raw external level, asynchronous to `clk`, may bounce.
- `out_signal`  output  1  debounced, registered level; feeds the change detector.
- `settling`  output  1  high while the synchronised input differs from `out_signal` (debounce in progress).

## Operation

- Synchroniser: two flops, `sync1 <= in_signal`, `sync2 <= sync1`. Only `sync2` is used downstream of the synchroniser. No logic is placed between the two flops.
- Debounce counter `cnt`, registered. Each rising edge:
  - If `sync2 == out_signal`: `cnt <= 0`. This is the IDLE condition.
  - Else, if `cnt == STABLE_CYCLES-1`: `out_signal <= sync2` and `cnt <= 0`. This is the COMMIT condition.
  - Else: `cnt <= cnt + 1`. This is the COUNT condition.
- Effective states are IDLE (`sync2 == out_signal`) and COUNTING (`sync2 != out_signal`). Transitions between them:
  - IDLE→COUNTING when `sync2` changes.
  - COUNTING→IDLE on COMMIT, or when `sync2` reverts to `out_signal`.
- A reversion clears `cnt` on the next edge. Any partial count is discarded and is never resumed.
- `settling = (sync2 != out_signal)`. It is purely a function of registers and is glitch-free.
- Behaviour is symmetric for rising and falling transitions.
- `cnt` never exceeds `STABLE_CYCLES-1`, and there is no wrap-around.
- `STABLE_CYCLES == 1`: COMMIT occurs on the first edge at which `sync2` differs from `out_signal`.
- Reset (`rst_n` low), asynchronous:
  - `sync1`, `sync2`, `out_signal` ← `RESET_VALUE`.
  - `cnt` ← 0.
  - `settling` ← 0.
- Reset mid-count discards all progress. After release, a full debounce interval is required again.
- While `rst_n` is low, `out_signal` holds `RESET_VALUE` regardless of `in_signal`.

## Timing

- Label edge E0 as the first rising edge at which a new `in_signal` level is sampled into `sync1`.
- E1: `sync2` takes the new level, and `settling` rises after E1.
- Counter increments occur on E2 … E(STABLE_CYCLES).
- COMMIT occurs on E(STABLE_CYCLES+1). `out_signal` changes after that edge, and `settling` falls after the same edge.
- Total latency from sample to output is therefore `STABLE_CYCLES+1` edges after E0. The input level must be held from E0 through E(STABLE_CYCLES).
- A pulse narrower than `STABLE_CYCLES` cycles at `sync2` never reaches `out_signal`.
- `out_signal` changes at most once per `STABLE_CYCLES` cycles.
- The downstream change detector adds its own latency; this block does not generate pulses.

## Test plan

All scenarios use `STABLE_CYCLES=4`, `RESET_VALUE=0` unless noted.

1. Reset: hold `rst_n=0` and toggle `in_signal` every cycle for 10 cycles → `out_signal=0` and `settling=0` throughout. Asserting `rst_n` asynchronously between edges forces outputs low immediately.
2. Clean rise and fall: drive `in_signal` 0→1 before E0 and hold it.
   - Required: `settling=1` after E1 through E4; `out_signal=0` through E4; `out_signal=1` after E5.
   - Then drive `in_signal` 1→0 and hold → `out_signal=0` exactly 5 edges after the new sample edge.
3. Glitch rejection: hold `in_signal=1` for 3 cycles, then return it to 0 → `out_signal` stays 0; `settling` pulses high for 3 cycles; `cnt` returns to 0.
4. Bounce: drive `in_signal` through the sequence 1,0,1,0,1 at one cycle each, then hold 1 → `out_signal` rises exactly 5 edges after the final 0→1 sample edge, with exactly one transition.
5. Reset mid-count: with `in_signal=1` held, assert `rst_n=0` after E3 and release it 2 cycles later.
   - Required: `out_signal` stays 0.
   - After release, `out_signal` rises only after a full 5 edges from the first post-reset sample edge.
6. Parameter corners:
   - `STABLE_CYCLES=1`: a 2-cycle-wide pulse passes, with `out_signal` following 2 edges late; a 1-cycle `sync2` pulse also passes.
   - `RESET_VALUE=1` with `in_signal` held at 1: `out_signal=1` from reset, and `settling` never asserts.

Source files
------------

// File: rtl/aidan_mcnay_debounce.sv
// Two-flop synchroniser followed by a stability counter: out_signal only
// follows the synchronised input once it has held a new level for STABLE_CYCLES edges.
module aidan_mcnay_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_signal,
  output logic out_signal,
  output logic settling
);

  localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          out_nxt;
  state_e        state;

  // Plain flop pair; nothing may sit between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= in_signal;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      out_signal <= RESET_VALUE;
    end else begin
      cnt        <= cnt_nxt;
      out_signal <= out_nxt;
    end
  end

  // State is implied by the registers; any reversion drops the partial count.
  always_comb begin
    cnt_nxt = '0;
    out_nxt = out_signal;
    state   = (sync2 != out_signal) ? COUNTING : IDLE;
    case (state)
      COUNTING: begin
        if (cnt == LAST) out_nxt = sync2;
        else             cnt_nxt = cnt + CW'(1);
      end
      default: ;
    endcase
  end

  assign settling = (sync2 != out_signal);

endmodule

// File: tb/tb_aidan_mcnay_debounce.sv
// Bench for aidan_mcnay_debounce: three instances (N=4/RV=0, N=1/RV=0, N=4/RV=1)
// checked against a sample-history model plus hand-derived edge timings.
module tb_aidan_mcnay_debounce;

  logic clk, rst_n;
  logic in4, in1, inr;
  logic out4, set4, out1, set1, outr, setr;
  logic [2:0] ins;
  int errors = 0;
  int checks = 0;

  assign ins = {inr, in1, in4};

  aidan_mcnay_debounce #(.STABLE_CYCLES(4), .RESET_VALUE(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_signal(in4), .out_signal(out4), .settling(set4));
  aidan_mcnay_debounce #(.STABLE_CYCLES(1), .RESET_VALUE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_signal(in1), .out_signal(out1), .settling(set1));
  aidan_mcnay_debounce #(.STABLE_CYCLES(4), .RESET_VALUE(1'b1)) ur (
    .clk(clk), .rst_n(rst_n), .in_signal(inr), .out_signal(outr), .settling(setr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: keep the history of synchronised samples since the last commit;
  // the output flips once the newest N samples all disagree with it.
  logic        m_s1 [3];
  logic        m_s2 [3];
  logic        m_out[3];
  logic [31:0] m_hist[3];

  function automatic logic [31:0] mask_of(int i);
    return (i == 1) ? 32'h1 : 32'hF;
  endfunction

  function automatic logic rv_of(int i);
    return (i == 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i]   <= rv_of(i);
        m_s2[i]   <= rv_of(i);
        m_out[i]  <= rv_of(i);
        m_hist[i] <= {32{rv_of(i)}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] <= ins[i];
        m_s2[i] <= m_s1[i];
        if ((({m_hist[i][30:0], m_s2[i]} ^ {32{m_out[i]}}) & mask_of(i)) == mask_of(i)) begin
          m_out[i]  <= ~m_out[i];
          m_hist[i] <= {32{~m_out[i]}};
        end else begin
          m_hist[i] <= {m_hist[i][30:0], m_s2[i]};
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in4 = ~in4; in1 = ~in1;
      @(negedge clk);
      checks++;
      if ({out4, set4, out1, set1, outr, setr} !== 6'b000010) begin
        errors++;
        $display("FAIL reset_hold k=%0d got out4/set4/out1/set1/outr/setr=%b exp=000010", k,
                 {out4, set4, out1, set1, outr, setr});
      end
    end
    in4 = 1'b0; in1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_rise_fall();
    for (int phase = 0; phase < 2; phase++) begin
      in4 = (phase == 0);
      for (int k = 1; k <= 8; k++) begin
        logic eo, es;
        @(negedge clk);
        eo = (phase == 0) ? (k >= 6) : (k < 6);
        es = (k >= 2 && k <= 5);
        checks++;
        if (out4 !== eo) begin
          errors++; $display("FAIL clean_out ph=%0d k=%0d got=%b exp=%b", phase, k, out4, eo);
        end
        checks++;
        if (set4 !== es) begin
          errors++; $display("FAIL clean_settling ph=%0d k=%0d got=%b exp=%b", phase, k, set4, es);
        end
        checks++;
        if (out4 !== m_out[0]) begin
          errors++; $display("FAIL clean_model ph=%0d k=%0d got=%b exp=%b", phase, k, out4, m_out[0]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int nset = 0;
    in4 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) in4 = 1'b0;
      if (set4) nset++;
      checks++;
      if (out4 !== 1'b0 || set4 !== (m_s2[0] != m_out[0])) begin
        errors++;
        $display("FAIL glitch k=%0d got out=%b set=%b exp out=0 set=%b", k, out4, set4, m_s2[0] != m_out[0]);
      end
    end
    checks++;
    if (nset != 3) begin
      errors++; $display("FAIL glitch_settle_width got=%0d exp=3", nset);
    end
    checks++;
    if (u4.cnt !== '0) begin
      errors++; $display("FAIL glitch_cnt_clear got=%0d exp=0", u4.cnt);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq;
    int trans = 0;
    logic prev;
    seq = 4'b0101;  // applied LSB first: 1,0,1,0 then the final held 1
    prev = out4;
    for (int j = 0; j < 4; j++) begin
      in4 = seq[j];
      @(negedge clk);
      checks++;
      if (out4 !== 1'b0) begin
        errors++; $display("FAIL bounce_early j=%0d got=%b exp=0", j, out4);
      end
    end
    in4 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out4 !== prev) trans++;
      prev = out4;
      checks++;
      if (out4 !== (k >= 6) || out4 !== m_out[0]) begin
        errors++; $display("FAIL bounce_rise k=%0d got=%b exp=%b model=%b", k, out4, k >= 6, m_out[0]);
      end
    end
    checks++;
    if (trans != 1) begin
      errors++; $display("FAIL bounce_transitions got=%0d exp=1", trans);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out4, set4, outr, setr} !== 4'b0010) begin
      errors++; $display("FAIL async_reset got out4/set4/outr/setr=%b exp=0010", {out4, set4, outr, setr});
    end
    @(negedge clk);
    in4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midcount();
    in4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (out4 !== 1'b0) begin
        errors++; $display("FAIL midcount_pre k=%0d got=%b exp=0", k, out4);
      end
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out4 !== 1'b0 || set4 !== 1'b0) begin
        errors++; $display("FAIL midcount_inreset k=%0d got out=%b set=%b exp 0/0", k, out4, set4);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (out4 !== (k >= 6) || out4 !== m_out[0]) begin
        errors++; $display("FAIL midcount_post k=%0d got=%b exp=%b model=%b", k, out4, k >= 6, m_out[0]);
      end
    end
    in4 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_n1_corner();
    int rises;
    // two-cycle pulse
    in1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) in1 = 1'b0;
      checks++;
      if (out1 !== (k == 3 || k == 4) || set1 !== (k == 2 || k == 4)) begin
        errors++;
        $display("FAIL n1_pulse2 k=%0d got out=%b set=%b exp out=%b set=%b", k, out1, set1,
                 k == 3 || k == 4, k == 2 || k == 4);
      end
    end
    // one-cycle pulse still passes
    rises = 0;
    in1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in1 = 1'b0;
      if (out1) rises++;
      checks++;
      if (out1 !== (k == 3) || out1 !== m_out[1]) begin
        errors++; $display("FAIL n1_pulse1 k=%0d got=%b exp=%b model=%b", k, out1, k == 3, m_out[1]);
      end
    end
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL n1_pulse1_width got=%0d exp=1", rises);
    end
  endtask

  task automatic test_reset_value();
    inr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in4 = 1'($urandom_range(0, 1));
      in1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (outr !== 1'b1 || setr !== 1'b0) begin
        errors++; $display("FAIL resetval k=%0d got out=%b set=%b exp 1/0", k, outr, setr);
      end
    end
  endtask

  task automatic test_random();
    int run4 = 0, run1 = 0, runr = 0;
    for (int k = 0; k < 600; k++) begin
      if (run4 == 0) begin in4 = ~in4; run4 = $urandom_range(1, 7); end
      if (run1 == 0) begin in1 = ~in1; run1 = $urandom_range(1, 3); end
      if (runr == 0) begin inr = ~inr; runr = $urandom_range(1, 7); end
      run4--; run1--; runr--;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({out4, set4, out1, set1, outr, setr} !==
          {m_out[0], m_s2[0] != m_out[0], m_out[1], m_s2[1] != m_out[1], m_out[2], m_s2[2] != m_out[2]}) begin
        errors++;
        $display("FAIL random k=%0d got=%b exp=%b", k, {out4, set4, out1, set1, outr, setr},
                 {m_out[0], m_s2[0] != m_out[0], m_out[1], m_s2[1] != m_out[1], m_out[2], m_s2[2] != m_out[2]});
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in4 = 1'b0; in1 = 1'b0; inr = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_rise_fall();
    test_glitch();
    test_bounce();
    test_async_reset();
    test_reset_midcount();
    test_n1_corner();
    test_reset_value();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
